// File: rtl/pe_mac_ctrl_pkg.sv
// rtl/pe_mac_ctrl_pkg.sv - shared types and default widths for the PE_MAC row controller

package pe_mac_ctrl_pkg;

  localparam int DEF_DW    = 8;
  localparam int DEF_AW    = 16;
  localparam int DEF_K_MAX = 64;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    OUT
  } pe_ctrl_state_e;

  typedef struct packed {
    logic [DEF_DW-1:0] m;
    logic [DEF_DW-1:0] f;
  } pe_pair_t;

endpackage

// File: rtl/pe_mac_ctrl.sv
// rtl/pe_mac_ctrl.sv - dot-product sequencer for one PE_MAC row (clear, stream, drain, result handshake)
// Optional stall timeout enabled by defining PE_MAC_CTRL_TIMEOUT_EN.

module pe_mac_ctrl
  import pe_mac_ctrl_pkg::*;
#(
  parameter int DW     = DEF_DW,
  parameter int AW     = DEF_AW,
  parameter int K_MAX  = DEF_K_MAX,
  parameter int CW     = $clog2(K_MAX + 1),
  parameter int PE_LAT = 1,
  parameter int TO_CYC = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] cfg_len,
  output logic          busy,
  output logic          done,
  output logic          err,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_m,
  input  logic [DW-1:0] in_f,
  output logic          pe_clr,
  output logic          pe_en,
  output logic [DW-1:0] pe_m,
  output logic [DW-1:0] pe_f,
  input  logic [AW-1:0] pe_mac,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_data
);

  localparam int DCW = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;

  pe_ctrl_state_e r_state, w_state_n;
  logic [CW-1:0]  r_len;
  logic [CW-1:0]  r_cnt;
  logic [DCW-1:0] r_dcnt;
  logic [AW-1:0]  r_data;
  logic           r_done;

  logic           w_hs;
  logic           w_last;
  logic           w_drain_end;
  logic [CW-1:0]  w_len_clamp;
  logic           w_timeout;

  assign w_hs        = in_valid && (r_state == STREAM);
  assign w_last      = w_hs && ((r_cnt + CW'(1)) == r_len);
  assign w_drain_end = (r_state == DRAIN) && (r_dcnt == DCW'(PE_LAT - 1));
  assign w_len_clamp = (cfg_len > CW'(K_MAX)) ? CW'(K_MAX) : cfg_len;

`ifdef PE_MAC_CTRL_TIMEOUT_EN
  localparam int SW = $clog2(TO_CYC + 1);
  logic [SW-1:0] r_stall;

  // Counts consecutive STREAM cycles without an operand handshake.
  always_ff @(posedge clk) begin
    if (rst || (r_state != STREAM) || w_hs) begin
      r_stall <= '0;
    end else begin
      r_stall <= r_stall + SW'(1);
    end
  end

  assign w_timeout = (r_state == STREAM) && !w_hs && (r_stall == SW'(TO_CYC - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_len   <= '0;
      r_cnt   <= '0;
      r_dcnt  <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_done  <= (r_state == OUT) && out_ready;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_len <= w_len_clamp;
            r_cnt <= '0;
            if (cfg_len == '0) begin
              r_data <= '0;
            end
          end
        end
        CLEAR: begin
          r_cnt  <= '0;
          r_dcnt <= '0;
        end
        STREAM: begin
          if (w_hs) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DRAIN: begin
          r_dcnt <= r_dcnt + DCW'(1);
          if (w_drain_end) begin
            r_data <= pe_mac;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Idle operand slots feed zeros so the PE accumulator holds its value.
  always_comb begin
    w_state_n = r_state;
    in_ready  = 1'b0;
    pe_clr    = 1'b0;
    pe_en     = 1'b0;
    pe_m      = '0;
    pe_f      = '0;
    out_valid = 1'b0;
    err       = w_timeout;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_n = (cfg_len == '0) ? OUT : CLEAR;
        end
      end
      CLEAR: begin
        pe_clr    = 1'b1;
        w_state_n = STREAM;
      end
      STREAM: begin
        in_ready = 1'b1;
        if (w_hs) begin
          pe_en = 1'b1;
          pe_m  = in_m;
          pe_f  = in_f;
        end
        if (w_timeout) begin
          pe_clr    = 1'b1;
          w_state_n = IDLE;
        end else if (w_last) begin
          w_state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (w_drain_end) begin
          w_state_n = OUT;
        end
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_n = IDLE;
        end
      end
      default: begin
        w_state_n = IDLE;
      end
    endcase
  end

  assign busy     = (r_state != IDLE);
  assign done     = r_done;
  assign out_data = r_data;

endmodule

// File: tb/tb_pe_mac_ctrl.sv
// tb/tb_pe_mac_ctrl.sv - self-checking bench for pe_mac_ctrl with a behavioural PE accumulator

module tb_pe_mac_ctrl;
  import pe_mac_ctrl_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 16;
  localparam int K_MAX = 64;
  localparam int CW    = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] cfg_len;
  logic          busy;
  logic          done;
  logic          err;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_m;
  logic [DW-1:0] in_f;
  logic          pe_clr;
  logic          pe_en;
  logic [DW-1:0] pe_m;
  logic [DW-1:0] pe_f;
  logic [AW-1:0] pe_mac;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_data;

  always #5 clk = ~clk;

  pe_mac_ctrl #(
    .DW(DW), .AW(AW), .K_MAX(K_MAX), .CW(CW), .PE_LAT(1), .TO_CYC(255)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
    .busy(busy), .done(done), .err(err),
    .in_valid(in_valid), .in_ready(in_ready), .in_m(in_m), .in_f(in_f),
    .pe_clr(pe_clr), .pe_en(pe_en), .pe_m(pe_m), .pe_f(pe_f), .pe_mac(pe_mac),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  // PE accumulator with one cycle of latency.
  logic [AW-1:0] r_acc;
  always @(posedge clk) begin
    if (rst || pe_clr) r_acc <= '0;
    else if (pe_en) r_acc <= r_acc + ({8'd0, pe_m} * {8'd0, pe_f});
  end
  assign pe_mac = r_acc;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  pe_pair_t vec[$];
  logic [AW-1:0] exp_q[$];

  int start_cyc = 0;
  int ov_cyc = 0;
  int en_cnt = 0;
  int done_total = 0;
  logic [AW-1:0] last_res = '0;
  logic prev_hs = 1'b0;
  logic prev_hold = 1'b0;
  logic prev_ov = 1'b0;
  logic [AW-1:0] prev_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic pe_pair_t pp(input int m, input int f);
    pe_pair_t p;
    p.m = m[7:0];
    p.f = f[7:0];
    return p;
  endfunction

  // Reference result: sum of products over the first min(len, K_MAX) pairs, modulo 2^AW.
  function automatic logic [AW-1:0] exp_dot(input int len);
    int n;
    int s;
    n = (len > K_MAX) ? K_MAX : len;
    s = 0;
    for (int i = 0; i < n; i++) s += int'(vec[i].m) * int'(vec[i].f);
    return s[AW-1:0];
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      prev_hs   = 1'b0;
      prev_hold = 1'b0;
      prev_ov   = 1'b0;
    end else begin
      chk("pe_en_rule", pe_en, in_valid && in_ready);
      chk("pe_m_feed", pe_m, (in_valid && in_ready) ? in_m : 8'd0);
      chk("pe_f_feed", pe_f, (in_valid && in_ready) ? in_f : 8'd0);
      chk("err_off", err, 0);
      chk("done_after_hs", done, prev_hs);
      if (prev_hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_data);
      end
      if (in_ready || out_valid || pe_clr || pe_en) chk("busy_active", busy, 1);
      if (start && !busy) begin
        start_cyc = cyc;
        en_cnt = 0;
      end
      if (pe_en) en_cnt++;
      if (done) done_total++;
      if (out_valid && !prev_ov) ov_cyc = cyc;
      if (out_valid && out_ready) begin
        chk("result_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("out_data_model", out_data, exp_q.pop_front());
        last_res = out_data;
      end
      prev_hs   = out_valid && out_ready;
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      prev_ov   = out_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int gap);
    logic ok;
    int k;
    for (int i = 0; i < vec.size(); i++) begin
      in_valid = 1'b0; in_m = '0; in_f = '0;
      repeat (gap) tick();
      in_valid = 1'b1; in_m = vec[i].m; in_f = vec[i].f;
      k = 0;
      do begin
        @(negedge clk);
        ok = in_ready;
        @(posedge clk);
        #1;
        k++;
      end while (!ok && k < 100);
      chk("feed_hs", ok, 1);
    end
    in_valid = 1'b0; in_m = '0; in_f = '0;
  endtask

  task automatic do_job(input int len, input int gap, input int hold,
                        output int lat, output int en, output logic [AW-1:0] res);
    int k;
    exp_q.push_back(exp_dot(len));
    out_ready = (hold == 0);
    start = 1'b1;
    cfg_len = CW'(len);
    tick();
    start = 1'b0;
    cfg_len = '0;
    if (vec.size() > 0) feed(gap);
    k = 0;
    while (!out_valid && k < 300) begin @(negedge clk); k++; end
    chk("out_valid_seen", out_valid, 1);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        tick();
        if (i == 2) begin start = 1'b1; cfg_len = CW'(2); end
        else begin start = 1'b0; cfg_len = '0; end
      end
      start = 1'b0;
      out_ready = 1'b1;
    end
    k = 0;
    while (!(out_valid && out_ready) && k < 300) begin @(negedge clk); k++; end
    chk("result_hs_seen", out_valid && out_ready, 1);
    tick();
    lat = ov_cyc - start_cyc;
    en = en_cnt;
    res = last_res;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int en;
    logic [AW-1:0] res;

    rst = 1'b1; start = 1'b0; cfg_len = '0; in_valid = 1'b0;
    in_m = '0; in_f = '0; out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_pe_clr", pe_clr, 0);
    chk("rst_pe_en", pe_en, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    tick();

    // len=3 back-to-back, then len=2 started in the done cycle
    vec = '{pp(2, 1), pp(3, 2), pp(4, 3)};
    do_job(3, 0, 0, lat, en, res);
    chk("j1_result", res, 20);
    chk("j1_latency", lat, 6);
    chk("j1_pe_en_cycles", en, 3);
    vec = '{pp(7, 7), pp(1, 1)};
    do_job(2, 0, 0, lat, en, res);
    chk("j2_result", res, 50);
    chk("j2_latency", lat, 5);
    chk("j2_pe_en_cycles", en, 2);

    // gaps of two idle cycles between pairs
    vec = '{pp(2, 1), pp(3, 2), pp(4, 3), pp(4, 0), pp(5, 0)};
    do_job(5, 2, 0, lat, en, res);
    chk("j3_result", res, 20);
    chk("j3_pe_en_cycles", en, 5);

    // zero length: no PE activity
    vec.delete();
    do_job(0, 0, 0, lat, en, res);
    chk("j4_result", res, 0);
    chk("j4_latency", lat, 1);
    chk("j4_pe_en_cycles", en, 0);

    // consumer stalls 10 cycles; start during OUT must be ignored
    vec = '{pp(3, 5), pp(6, 7)};
    do_job(2, 0, 10, lat, en, res);
    chk("j5_result", res, 57);
    repeat (4) tick();
    chk("j5_start_ignored", busy, 0);

    // accumulator wrap modulo 2^16
    vec = '{pp(255, 255), pp(255, 255), pp(255, 255), pp(255, 255)};
    do_job(4, 0, 0, lat, en, res);
    chk("j6_wrap_result", res, 63492);

    // length above K_MAX clamps to 64
    vec.delete();
    for (int i = 0; i < 64; i++) vec.push_back(pp(1, 2));
    do_job(70, 0, 0, lat, en, res);
    chk("j7_clamp_result", res, 128);
    chk("j7_pe_en_cycles", en, 64);
    chk("j7_latency", lat, 67);

    // reset mid-STREAM aborts with no result and no done
    vec = '{pp(9, 9), pp(2, 2)};
    out_ready = 1'b1;
    start = 1'b1; cfg_len = CW'(4);
    tick();
    start = 1'b0; cfg_len = '0;
    feed(0);
    chk("abort_in_stream", in_ready, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_data", out_data, 0);
    chk("abort_pe_clr", pe_clr, 0);
    chk("abort_pe_en", pe_en, 0);
    chk("abort_done", done, 0);
    chk("abort_err", err, 0);
    repeat (6) tick();
    chk("abort_still_idle", busy, 0);
    chk("done_pulse_total", done_total, 7);
    chk("results_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
